// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: byte type, FSM state, id width helper.
package Definitions_Package;

  typedef logic [7:0] word_lenght_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  // Index width for a requester count; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_sel.sv
// Round-robin pick: first set request found searching upward from last_grant+1, wrapping.
module rr_priority_sel
  import Definitions_Package::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]            req,
  input  logic [id_width(NUM_REQ)-1:0]  last_grant,
  output logic [id_width(NUM_REQ)-1:0]  winner,
  output logic                          found
);

  localparam int IDW = id_width(NUM_REQ);

  // Walk offsets 1..NUM_REQ so the previous owner is the last one considered.
  always_comb begin
    int               idx;
    logic [IDW-1:0]   sel;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      sel = IDW'(idx);
      if (!found && req[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters. Round-robin grant,
// one-cycle load/ack, frame watchdog with sticky error, enforced idle gap.
module uart_tx_arbiter
  import Definitions_Package::*;
#(
  parameter int          NUM_REQ    = 4,
  parameter logic [15:0] TIMEOUT    = 16'd6000,
  parameter logic [7:0]  GAP_CYCLES = 8'd16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic         [NUM_REQ-1:0]        req_valid,
  input  word_lenght_t [NUM_REQ-1:0]        req_data,
  output logic         [NUM_REQ-1:0]        req_ack,
  output word_lenght_t                      tx_data,
  output logic                              tx_load,
  input  logic                              tx_done,
  output logic         [id_width(NUM_REQ)-1:0] grant_id,
  output logic                              busy,
  input  logic                              err_clr,
  output logic                              timeout_err
);

  localparam int          IDW      = id_width(NUM_REQ);
  // Last timer value allowed to see tx_done; a zero setting degenerates to one cycle.
  localparam logic [15:0] TO_LAST  = (TIMEOUT == 16'd0) ? 16'd0 : TIMEOUT - 16'd1;
  localparam logic [7:0]  GAP_LAST = (GAP_CYCLES == 8'd0) ? 8'd0 : GAP_CYCLES - 8'd1;

  arb_state_t     state, state_nxt;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] winner;
  logic           found;
  logic [15:0]    timer;
  logic [7:0]     gap_cnt;
  logic           timeout_hit;

  rr_priority_sel #(.NUM_REQ(NUM_REQ)) u_sel (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .found      (found)
  );

  // tx_done on the final cycle still counts as a completed frame.
  assign timeout_hit = (state == WAIT) && !tx_done && (timer == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and decoded strobes; load/ack exist only in LOAD.
  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    req_ack   = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (found) state_nxt = LOAD;
      LOAD: begin
        tx_load           = 1'b1;
        req_ack[grant_id] = 1'b1;
        state_nxt         = WAIT;
      end
      WAIT: if (tx_done || timeout_hit) state_nxt = GAP;
      GAP:  if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, round-robin pointer, and saturating frame/gap counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_id   <= '0;
      tx_data    <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      timer      <= '0;
      gap_cnt    <= '0;
    end else begin
      if (state == IDLE && found) begin
        grant_id <= winner;
        tx_data  <= req_data[winner];
      end
      if (state == LOAD) begin
        last_grant <= grant_id;
        timer      <= '0;
      end else if (state == WAIT && timer != '1) begin
        timer <= timer + 16'd1;
      end
      if (state == WAIT)
        gap_cnt <= '0;
      else if (state == GAP && gap_cnt != '1)
        gap_cnt <= gap_cnt + 8'd1;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             timeout_err <= 1'b0;
    else if (timeout_hit) timeout_err <= 1'b1;
    else if (err_clr)     timeout_err <= 1'b0;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: vector table of grant sequences plus hand-written
// timeout, collision, gap, dropped-request and mid-frame reset sequences.
// Every tx_load is matched against a queue of expected grants.
module tb_uart_tx_arbiter;
  import Definitions_Package::*;

  localparam int GAP = 16;
  localparam int TO  = 50;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [3:0]               req_valid;
  word_lenght_t [3:0]       req_data;
  logic [3:0]               req_ack;
  word_lenght_t             tx_data;
  logic                     tx_load;
  logic                     tx_done;
  logic [1:0]               grant_id;
  logic                     busy;
  logic                     err_clr;
  logic                     timeout_err;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(16'(TO)), .GAP_CYCLES(8'(GAP))) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_clr     (err_clr),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] grant;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  grant;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[12];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every load must match the oldest expected grant.
  always @(negedge clk) begin
    if (rst === 1'b1 && (tx_load || req_ack != 4'b0000)) begin
      if (!tx_load) chk("ack_without_load", {28'd0, req_ack}, 32'd0);
      else if (exp_q.size() == 0) chk("unexpected_load", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("grant_id", {30'd0, grant_id}, {30'd0, e.grant});
        chk("tx_data", {24'd0, tx_data}, {24'd0, e.data});
        chk("req_ack", {28'd0, req_ack}, {28'd0, 4'b0001 << e.grant});
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the LOAD cycle.
  task automatic start_frame(input logic [3:0] v, input logic [31:0] d, input logic [1:0] g);
    exp_t e;
    e.grant = g;
    e.data  = d[int'(g)*8 +: 8];
    exp_q.push_back(e);
    req_valid = v;
    req_data  = d;
    @(posedge clk);
    @(negedge clk);
    chk("load_latency", {31'd0, tx_load}, 32'd1);
    req_valid = '0;
  endtask

  task automatic pulse_done_after(input int d);
    repeat (d) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  initial begin
    int k;
    // valid, {d3,d2,d1,d0}, expected winner given the history of previous rows
    vecs[0]  = '{4'b0001, 32'h000000A5, 2'd0};
    vecs[1]  = '{4'b1111, 32'h44332211, 2'd1};
    vecs[2]  = '{4'b1111, 32'h88776655, 2'd2};
    vecs[3]  = '{4'b1111, 32'hCCBBAA99, 2'd3};
    vecs[4]  = '{4'b1111, 32'h1F2E3D4C, 2'd0};
    vecs[5]  = '{4'b0100, 32'h00F00000, 2'd2};
    vecs[6]  = '{4'b0011, 32'h00005A3C, 2'd0};
    vecs[7]  = '{4'b1010, 32'hDE00AD00, 2'd1};
    vecs[8]  = '{4'b1000, 32'h7E000000, 2'd3};
    vecs[9]  = '{4'b0110, 32'h00C3B200, 2'd1};
    vecs[10] = '{4'b1001, 32'h11000022, 2'd3};
    vecs[11] = '{4'b1001, 32'h11000022, 2'd0};

    rst = 1'b0; req_valid = '0; req_data = '0; tx_done = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {15'd0, tx_load, req_ack, tx_data, grant_id, busy, timeout_err}, 32'd0);
    rst = 1'b1;
    // tx_done while idle must not start anything
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {31'd0, busy}, 32'd0);

    // Round-robin table; frames are kept shorter than TIMEOUT
    foreach (vecs[i]) begin
      start_frame(vecs[i].valid, vecs[i].data, vecs[i].grant);
      pulse_done_after(30);
      wait_idle();
    end
    chk("no_err_after_table", {31'd0, timeout_err}, 32'd0);

    // Timeout: tx_load in cycle L, last tx_done chance in L+TO, flag seen L+TO+1
    start_frame(4'b0010, 32'h00005E00, 2'd1);
    repeat (TO) @(negedge clk);
    chk("err_before_timeout", {31'd0, timeout_err}, 32'd0);
    err_clr = 1'b1;                      // set must beat clear on this edge
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_set", {31'd0, timeout_err}, 32'd1);
    repeat (GAP - 1) @(negedge clk);
    chk("gap_after_timeout", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("idle_after_gap", {31'd0, busy}, 32'd0);
    chk("err_sticky", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", {31'd0, timeout_err}, 32'd0);

    // Collision: tx_done on the last allowed cycle wins over timeout
    start_frame(4'b0100, 32'h00660000, 2'd2);
    pulse_done_after(TO);
    chk("collision_no_err", {31'd0, timeout_err}, 32'd0);
    chk("collision_in_gap", {31'd0, busy}, 32'd1);
    wait_idle();

    // Gap: request right after tx_done; GAP cycles, one IDLE, then LOAD
    start_frame(4'b1000, 32'h3C000000, 2'd3);
    repeat (10) @(negedge clk);
    tx_done = 1'b1;                      // cycle D
    @(negedge clk);
    tx_done   = 1'b0;
    req_valid = 4'b0010;
    req_data  = 32'h00004B00;
    begin
      exp_t e;
      e.grant = 2'd1; e.data = 8'h4B;
      exp_q.push_back(e);
    end
    k = 1;
    while (!tx_load && k < 60) begin
      @(negedge clk);
      k++;
      tx_done = (k == 5);                // stray tx_done inside GAP is ignored
    end
    tx_done   = 1'b0;
    req_valid = '0;
    chk("gap_latency", 32'(k), 32'(GAP + 2));
    pulse_done_after(10);
    wait_idle();

    // Request raised and dropped during GAP never gets a frame
    start_frame(4'b0001, 32'h000000E1, 2'd0);
    pulse_done_after(10);
    req_valid = 4'b0100;
    repeat (3) @(negedge clk);
    req_valid = '0;
    wait_idle();
    repeat (2) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("dropped_req_idle", {31'd0, busy}, 32'd0);

    // Reset in WAIT: outputs clear without a clock edge; no load after release
    start_frame(4'b0100, 32'h009C0000, 2'd2);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_async", {15'd0, tx_load, req_ack, tx_data, grant_id, busy, timeout_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", {31'd0, busy}, 32'd0);
    start_frame(4'b1000, 32'hA7000000, 2'd3);
    pulse_done_after(10);
    wait_idle();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter.
REQ-002 SHALL have parameter TIMEOUT, default 16'd6000, max clk cycles from load to tx_done before abort.
REQ-003 SHALL have parameter GAP_CYCLES, default 8'd16, idle clk cycles enforced between frames.
REQ-004 SHALL have one clock; reset is asynchronous and active-low; the ports are named clk and rst.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  NUM_REQ  per-requester byte pending, held until ack.
REQ-008 req_data  input  NUM_REQ x word_lenght_t  per-requester byte, stable while req_valid high.
REQ-009 req_ack  output  NUM_REQ  one-hot one-cycle pulse, byte accepted.
REQ-010 tx_data  output  word_lenght_t  byte to transmitter, registered.
REQ-011 tx_load  output  1  one-cycle pulse starting a transmitter frame.
REQ-012 tx_done  input  1  one-cycle pulse from transmitter at frame end.
REQ-013 grant_id  output  $clog2(NUM_REQ)  index of current owner.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 err_clr  input  1  synchronous clear of timeout_err.
REQ-016 timeout_err  output  1  sticky flag, a frame timed out.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WAIT, GAP.
REQ-018 IDLE: any req_valid high -> latch winner index into grant_id and its req_data into tx_data, go LOAD; else stay.
REQ-019 Winner SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 has first priority.
REQ-020 LOAD: exactly one cycle; tx_load=1 and req_ack[grant_id]=1 together; last_grant<=grant_id; timer cleared; go WAIT.
REQ-021 Latency: req_valid sampled in IDLE at edge N -> tx_load/req_ack high in cycle N+1.
REQ-022 WAIT: timer increments each cycle; tx_done -> GAP; timer==TIMEOUT-1 without tx_done -> set timeout_err, go GAP.
REQ-023 tx_done and timeout in the same cycle: tx_done wins, timeout_err unchanged.
REQ-024 GAP: count GAP_CYCLES cycles, then IDLE; requests are not sampled during GAP.
REQ-025 tx_done in IDLE, LOAD or GAP SHALL be ignored.
REQ-026 req_valid dropped before grant: no ack and no frame for that requester; no state change.
REQ-027 timeout_err: set has priority over err_clr in the same cycle; otherwise err_clr clears.
REQ-028 tx_load, req_ack SHALL never be high outside LOAD; at most one req_ack bit high.
REQ-029 timer and gap counter SHALL saturate, never wrap.

Reset
REQ-030 rst low SHALL asynchronously force state IDLE, tx_load=0, req_ack=0, tx_data=0, grant_id=0, busy=0, timeout_err=0, timers=0, last_grant=NUM_REQ-1.
REQ-031 Reset mid-frame SHALL abort with no tx_load or ack after release; first grant after reset follows REQ-019.

Structure
REQ-032 word_lenght_t and the FSM state enum arb_state_t SHALL live in Definitions_Package.
REQ-033 Round-robin selection SHALL be a sub-module rr_priority_sel (combinational: req vector + last_grant -> winner index + found).
REQ-034 Timer and gap counter SHALL be inside uart_tx_arbiter; the block sits between requesters and UART_TX, tx_load driving its TX_en.

Verification
REQ-035 Single: req_valid=4'b0001, req_data[0]=8'hA5 -> next cycle tx_load=1, req_ack=4'b0001, tx_data=8'hA5, grant_id=0.
REQ-036 Round-robin: req_valid=4'b1111 held, tx_done 100 cycles after each load -> grant order 0,1,2,3,0; each ack once per frame.
REQ-037 Timeout: TIMEOUT=50, no tx_done -> timeout_err rises 50 cycles after tx_load; GAP then IDLE; err_clr pulse -> 0.
REQ-038 Collision: tx_done on exact timeout cycle -> timeout_err stays 0.
REQ-039 Gap: tx_done then req_valid=4'b0010 immediately -> next tx_load no earlier than GAP_CYCLES+1 cycles after tx_done.
REQ-040 Reset in WAIT: rst low 3 cycles -> all outputs 0 asynchronously; after release req_valid=4'b1000 -> grant_id=3, tx_load one cycle later.
